// File: rtl/mul_arb_pkg.sv
// Shared constants and helpers for the multiplier-sharing arbiter.
// Optional statistics counters are built only when MUL_ARB_STATS_EN is defined.
package mul_arb_pkg;

    localparam int W      = 13;
    localparam int LAT    = 2;
    localparam int STAT_W = 16;

    typedef logic [STAT_W-1:0] stat_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic stat_t sat_inc(input stat_t v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: the first valid requester after 'last' wins.
// Produces a one-hot grant, the winner index and a found flag.
module rr_arbiter_core #(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [TAGW-1:0] last,
    output logic [NREQ-1:0] grant,
    output logic [TAGW-1:0] g,
    output logic            found
);

    // Scanning starts one past the previous winner, so it ranks lowest next time.
    always_comb begin
        int idx;
        grant = '0;
        g     = last;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last) + off) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                g          = TAGW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined signed multiplier among NREQ requesters with a tagged result stream.
// Defining MUL_ARB_STATS_EN adds saturating grant/stall/idle counters.
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = mul_arb_pkg::W,
    parameter int LAT  = mul_arb_pkg::LAT,
    parameter int TAGW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic                 mul_ce,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [W-1:0]         mul_p,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [W-1:0]         res_data,
    output logic [TAGW-1:0]      res_tag
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [NREQ*mul_arb_pkg::STAT_W-1:0] stat_grants,
    output logic [mul_arb_pkg::STAT_W-1:0]      stat_stall,
    output logic [mul_arb_pkg::STAT_W-1:0]      stat_idle
`endif
);

    import mul_arb_pkg::*;

    logic [LAT-1:0]  vld;
    logic [TAGW-1:0] tag [LAT];
    logic [TAGW-1:0] last;
    logic [NREQ-1:0] grant;
    logic [TAGW-1:0] g;
    logic            found;
    logic            adv;
    logic            accept;

    rr_arbiter_core #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_rr (
        .req_valid (req_valid),
        .last      (last),
        .grant     (grant),
        .g         (g),
        .found     (found)
    );

    // The whole pipeline, core included, moves only when the result slot can drain.
    assign adv       = !res_valid || res_ready;
    assign mul_ce    = adv;
    assign accept    = found && adv && !reset;
    assign req_ready = (adv && !reset) ? grant : '0;
    assign mul_a     = reset ? '0 : req_a[int'(g)*W +: W];
    assign mul_b     = reset ? '0 : req_b[int'(g)*W +: W];

    assign res_valid = vld[LAT-1];
    assign res_tag   = tag[LAT-1];
    assign res_data  = mul_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld  <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag[k] <= '0;
            end
            last <= TAGW'(NREQ - 1);
        end else if (adv) begin
            vld[0] <= accept;
            for (int k = 1; k < LAT; k++) begin
                vld[k] <= vld[k-1];
                tag[k] <= tag[k-1];
            end
            if (accept) begin
                tag[0] <= g;
                last   <= g;
            end
        end
    end

`ifdef MUL_ARB_STATS_EN
    stat_t grant_cnt [NREQ];
    stat_t stall_cnt;
    stat_t idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
            stall_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            if (accept) begin
                grant_cnt[g] <= sat_inc(grant_cnt[g]);
            end
            if (res_valid && !res_ready) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (adv && !accept) begin
                idle_cnt <= sat_inc(idle_cnt);
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign stat_grants[i*STAT_W +: STAT_W] = grant_cnt[i];
    end
    assign stat_stall = stall_cnt;
    assign stat_idle  = idle_cnt;
`endif

endmodule
